alu_arbiter: RTL and testbench

- Shares the single execute-stage ALU between NUM_REQ execute units: jump, branch, arithmetic and load/store address.
- Each unit raises a request carrying 33-bit operands and a 5-bit ALU op.
- The arbiter grants requests round-robin, sequences the ALU through a start/done handshake, and returns the result to the granted unit.
- It sits between the execute units and the ALU. Its watchdog and flush abort protect the pipeline from a stalled or stale operation.

---
 rtl/execute_pkg.sv | 18 +
 rtl/rr_select.sv | 35 +++
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared execute-stage definitions: ALU op codes, operand/result widths and
// the arbiter state encoding. Imported by the ALU arbiter and its neighbours.
package execute_pkg;

    localparam int OPW  = 33;   // operand width
    localparam int RESW = 32;   // ALU result width
    localparam int OPCW = 5;    // ALU op code width

    localparam logic [OPCW-1:0] ALU_ADD     = 5'd0;
    localparam logic [OPCW-1:0] ALU_UNKNOWN = 5'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin priority picker (combinational).
// Ports:
//   req_valid  - request vector, one bit per requester
//   rr_ptr     - index with highest priority this cycle
//   any_valid  - at least one request bit is set
//   sel_idx    - first set bit scanning upward from rr_ptr with wrap
module rr_select #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic               any_valid,
    output logic [IW-1:0]      sel_idx
);

    // one spare bit so rr_ptr + offset can be compared against NUM_REQ
    logic [IW:0] cand;

    assign any_valid = |req_valid;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        sel_idx = rr_ptr;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ))
                cand = cand - (IW+1)'(NUM_REQ);
            if (req_valid[cand[IW-1:0]])
                sel_idx = cand[IW-1:0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing the execute-stage ALU between NUM_REQ units.
// Ports:
//   clk, reset_n                   - clock, synchronous active-low reset
//   req_valid/req_a/req_b/req_op   - packed per-unit requests
//   flush                          - aborts any in-flight operation
//   alu_in_a/alu_in_b/alu_op       - operands and op code to the ALU
//   alu_start/alu_abort            - one-cycle ALU control pulses
//   alu_done/alu_result            - ALU completion and result
//   grant                          - one-hot owner of the current operation
//   resp_valid/resp_result         - one-hot one-cycle result strobe + data
//   resp_timeout                   - response is a watchdog timeout
//   busy                           - arbiter is not idle
//
// state | meaning
// IDLE  | arbitrate among valid requests (suppressed by flush)
// BUSY  | operation issued, waiting for alu_done / watchdog / flush
// DONE  | response strobe cycle, then advance round-robin pointer
module alu_arbiter
    import execute_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OPW-1:0]  req_a,
    input  logic [NUM_REQ*OPW-1:0]  req_b,
    input  logic [NUM_REQ*OPCW-1:0] req_op,
    input  logic                    flush,
    output logic [OPW-1:0]          alu_in_a,
    output logic [OPW-1:0]          alu_in_b,
    output logic [OPCW-1:0]         alu_op,
    output logic                    alu_start,
    output logic                    alu_abort,
    input  logic                    alu_done,
    input  logic [RESW-1:0]         alu_result,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [RESW-1:0]         resp_result,
    output logic                    resp_timeout,
    output logic                    busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]      T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0]      IDX_LAST = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    arb_state_t          state, state_nx;
    logic [IW-1:0]       rr_ptr, rr_ptr_nx, idx, idx_nx, idx_inc;
    logic [TW-1:0]       timer, timer_nx;
    logic [OPW-1:0]      a_nx, b_nx, sel_a, sel_b;
    logic [OPCW-1:0]     op_nx, sel_op;
    logic                start_nx, abort_nx, rt_nx;
    logic [NUM_REQ-1:0]  grant_nx, rv_nx;
    logic [RESW-1:0]     rr_nx;
    logic                any_valid;
    logic [IW-1:0]       sel_idx;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .sel_idx   (sel_idx)
    );

    // explicit wrap so non-power-of-two NUM_REQ never points past the end
    assign idx_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign busy    = (state != IDLE);

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_UNKNOWN;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_a  = req_a[i*OPW +: OPW];
                sel_b  = req_b[i*OPW +: OPW];
                sel_op = req_op[i*OPCW +: OPCW];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        rr_ptr_nx = rr_ptr;
        idx_nx    = idx;
        timer_nx  = timer;
        a_nx      = alu_in_a;
        b_nx      = alu_in_b;
        op_nx     = alu_op;
        start_nx  = 1'b0;
        abort_nx  = 1'b0;
        grant_nx  = grant;
        rv_nx     = '0;
        rr_nx     = resp_result;
        rt_nx     = resp_timeout;
        unique case (state)
            IDLE: begin
                if (any_valid && !flush) begin
                    idx_nx   = sel_idx;
                    a_nx     = sel_a;
                    b_nx     = sel_b;
                    op_nx    = sel_op;
                    grant_nx = ONE << sel_idx;
                    timer_nx = '0;
                    start_nx = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // flush beats alu_done; alu_done beats the watchdog
                if (flush) begin
                    abort_nx  = 1'b1;
                    rr_ptr_nx = idx_inc;
                    grant_nx  = '0;
                    op_nx     = ALU_UNKNOWN;
                    state_nx  = IDLE;
                end else if (alu_done) begin
                    rr_nx    = alu_result;
                    rt_nx    = 1'b0;
                    rv_nx    = ONE << idx;
                    state_nx = DONE;
                end else if (timer == T_LAST) begin
                    abort_nx = 1'b1;
                    rr_nx    = '0;
                    rt_nx    = 1'b1;
                    rv_nx    = ONE << idx;
                    state_nx = DONE;
                end else if (timer != {TW{1'b1}}) begin
                    timer_nx = timer + 1'b1;
                end
            end
            DONE: begin
                rr_ptr_nx = idx_inc;
                grant_nx  = '0;
                op_nx     = ALU_UNKNOWN;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            idx          <= '0;
            timer        <= '0;
            alu_in_a     <= '0;
            alu_in_b     <= '0;
            alu_op       <= ALU_UNKNOWN;
            alu_start    <= 1'b0;
            alu_abort    <= 1'b0;
            grant        <= '0;
            resp_valid   <= '0;
            resp_result  <= '0;
            resp_timeout <= 1'b0;
        end else begin
            state        <= state_nx;
            rr_ptr       <= rr_ptr_nx;
            idx          <= idx_nx;
            timer        <= timer_nx;
            alu_in_a     <= a_nx;
            alu_in_b     <= b_nx;
            alu_op       <= op_nx;
            alu_start    <= start_nx;
            alu_abort    <= abort_nx;
            grant        <= grant_nx;
            resp_valid   <= rv_nx;
            resp_result  <= rr_nx;
            resp_timeout <= rt_nx;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter. The bench plays the execute units and the
// ALU; a transaction-level model (owner index, BUSY cycle count, pointer)
// predicts every output after each clock edge.
module tb_alu_arbiter;
    import execute_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*OPW-1:0]  req_a = '0, req_b = '0;
    logic [N*OPCW-1:0] req_op = '0;
    logic              flush = 1'b0;
    logic [OPW-1:0]    alu_in_a, alu_in_b;
    logic [OPCW-1:0]   alu_op;
    logic              alu_start, alu_abort;
    logic              alu_done = 1'b0;
    logic [RESW-1:0]   alu_result = '0;
    logic [N-1:0]      grant, resp_valid;
    logic [RESW-1:0]   resp_result;
    logic              resp_timeout, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_op(req_op), .flush(flush), .alu_in_a(alu_in_a),
        .alu_in_b(alu_in_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_abort(alu_abort), .alu_done(alu_done), .alu_result(alu_result),
        .grant(grant), .resp_valid(resp_valid), .resp_result(resp_result),
        .resp_timeout(resp_timeout), .busy(busy)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // execute units
    logic [OPW-1:0]  ua [N];
    logic [OPW-1:0]  ub [N];
    logic [OPCW-1:0] uop[N];
    bit              req_on[N];

    // reference model
    int              m_owner = -1;   // unit holding the ALU, -1 when idle
    bit              m_resp  = 1'b0; // response strobe cycle in progress
    int              m_cycles = 0;   // BUSY cycles elapsed for current op
    int              m_ptr   = 0;
    logic [OPW-1:0]  e_a = '0, e_b = '0;
    logic [OPCW-1:0] e_op = ALU_UNKNOWN;
    logic            e_start = 1'b0, e_abort = 1'b0, e_to = 1'b0, e_busy = 1'b0;
    logic [N-1:0]    e_grant = '0, e_rv = '0;
    logic [RESW-1:0] e_res = '0;

    int unsigned p_req, p_done, p_flush, p_drop, p_rst;

    task automatic model_step();
        int pick;
        pick    = -1;
        e_start = 1'b0;
        e_abort = 1'b0;
        e_rv    = '0;
        if (!reset_n) begin
            m_owner = -1; m_resp = 1'b0; m_ptr = 0;
            e_a = '0; e_b = '0; e_op = ALU_UNKNOWN;
            e_grant = '0; e_res = '0; e_to = 1'b0;
        end else if (m_owner < 0) begin
            if (!flush) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                if (pick >= 0) begin
                    m_owner  = pick;
                    m_cycles = 0;
                    e_a      = ua[pick];
                    e_b      = ub[pick];
                    e_op     = uop[pick];
                    e_grant  = N'(1) << pick;
                    e_start  = 1'b1;
                end
            end
        end else if (m_resp) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_resp  = 1'b0;
            e_grant = '0;
            e_op    = ALU_UNKNOWN;
        end else begin
            m_cycles++;
            if (flush) begin
                e_abort = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                e_grant = '0;
                e_op    = ALU_UNKNOWN;
            end else if (alu_done) begin
                e_rv   = N'(1) << m_owner;
                e_res  = alu_result;
                e_to   = 1'b0;
                m_resp = 1'b1;
            end else if (m_cycles == TO) begin
                e_abort = 1'b1;
                e_rv    = N'(1) << m_owner;
                e_res   = '0;
                e_to    = 1'b1;
                m_resp  = 1'b1;
            end
        end
        e_busy = (m_owner >= 0);
    endtask

    task automatic drive_inputs(input bit force_rst);
        logic [OPW-1:0] sum;
        for (int i = 0; i < N; i++)
            if (e_rv[i]) req_on[i] = 1'b0;
        if (m_owner >= 0 && !m_resp && $urandom_range(99) < p_drop)
            req_on[m_owner] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!req_on[i] && m_owner != i && $urandom_range(99) < p_req) begin
                req_on[i] = 1'b1;
                ua[i]  = {1'($urandom_range(1)), $urandom()};
                ub[i]  = {1'($urandom_range(1)), $urandom()};
                uop[i] = ($urandom_range(1) == 0) ? ALU_ADD : 5'($urandom_range(31));
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = req_on[i];
            req_a[i*OPW +: OPW]    = ua[i];
            req_b[i*OPW +: OPW]    = ub[i];
            req_op[i*OPCW +: OPCW] = uop[i];
        end
        flush      = ($urandom_range(99) < p_flush);
        reset_n    = !(force_rst || $urandom_range(999) < p_rst);
        alu_done   = ($urandom_range(99) < p_done);
        sum        = e_a + e_b;
        alu_result = alu_done ? sum[RESW-1:0] : $urandom();
    endtask

    task automatic compare_outputs();
        check_val("grant", 64'(grant), 64'(e_grant));
        check_val("alu_start", 64'(alu_start), 64'(e_start));
        check_val("alu_abort", 64'(alu_abort), 64'(e_abort));
        check_val("resp_valid", 64'(resp_valid), 64'(e_rv));
        check_val("busy", 64'(busy), 64'(e_busy));
        check_val("alu_op", 64'(alu_op), 64'(e_op));
        check_val("alu_in_a", 64'(alu_in_a), 64'(e_a));
        check_val("alu_in_b", 64'(alu_in_b), 64'(e_b));
        if (e_rv != '0) begin
            check_val("resp_result", 64'(resp_result), 64'(e_res));
            check_val("resp_timeout", 64'(resp_timeout), 64'(e_to));
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ua[i] = '0; ub[i] = '0; uop[i] = ALU_ADD; req_on[i] = 1'b0;
        end
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin p_req = 0;   p_done = 100; p_flush = 0;  p_drop = 0; p_rst = 0;  end
                1: begin p_req = 100; p_done = 100; p_flush = 0;  p_drop = 0; p_rst = 0;  end
                2: begin p_req = 40;  p_done = 20;  p_flush = 0;  p_drop = 5; p_rst = 0;  end
                3: begin p_req = 50;  p_done = 0;   p_flush = 0;  p_drop = 0; p_rst = 0;  end
                4: begin p_req = 60;  p_done = 30;  p_flush = 15; p_drop = 3; p_rst = 20; end
                default: begin p_req = 30; p_done = 15; p_flush = 5; p_drop = 5; p_rst = 5; end
            endcase
            for (int c = 0; c < 300; c++) begin
                if (ph == 0 && c == 2) begin
                    // single request from unit 1: 0x1000 + 0x10
                    req_on[1] = 1'b1;
                    ua[1]     = 33'h1000;
                    ub[1]     = 33'h10;
                    uop[1]    = ALU_ADD;
                end
                drive_inputs(ph == 0 && c < 2);
                model_step();
                @(posedge clk);
                #1;
                compare_outputs();
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
